// File: rtl/taxi_axil_rr_arb.sv
// Round-robin grant arbiter for a shared AXI4-lite resource; the owner keeps the grant until it acks.
// Optional watchdog compiled in with `define TAXI_AXIL_RR_ARB_TIMEOUT_EN.
module taxi_axil_rr_arb #(
   parameter int unsigned PORTS   = 4,
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned IDX_W   = (PORTS > 1) ? $clog2(PORTS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PORTS-1:0] req,
   input  logic [PORTS-1:0] ack,
   output logic [PORTS-1:0] grant,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_index,
   output logic             timeout,
   output logic [IDX_W-1:0] timeout_index
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] ptr, ptr_nxt;
   logic [PORTS-1:0] grant_nxt;
   logic             grant_valid_nxt;
   logic [IDX_W-1:0] grant_index_nxt;
   logic             timeout_nxt;
   logic [IDX_W-1:0] timeout_index_nxt;

   logic             honoured;
   logic             fire;
   logic             release_c;
   logic [PORTS-1:0] cand;
   logic [IDX_W-1:0] base;
   logic             sel_found;
   logic [IDX_W-1:0] sel_idx;

   // Only the owner's ack bit counts; grant is one-hot so masking with it isolates that bit.
   assign honoured = (state == BUSY) && |(ack & grant);

`ifdef TAXI_AXIL_RR_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] cnt, cnt_nxt;

   // An ack in the limit cycle wins over the watchdog.
   assign fire = (state == BUSY) && !honoured && (cnt == CNT_W'(TIMEOUT - 1));
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = |TIMEOUT;
   assign fire = 1'b0;
`endif

   assign release_c = honoured || fire;

   // On release the search restarts just past the releasing owner, which is excluded.
   always_comb begin
      cand = req;
      base = ptr;
      if (release_c) begin
         cand = req & ~grant;
         base = IDX_W'((int'(grant_index) + 1) % PORTS);
      end
   end

   // First candidate at or above base, wrapping; scanned downward so the lowest offset wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = PORTS - 1; i >= 0; i--) begin
         if (cand[(int'(base) + i) % PORTS]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'((int'(base) + i) % PORTS);
         end
      end
   end

   always_comb begin
      state_nxt         = state;
      ptr_nxt           = ptr;
      grant_nxt         = grant;
      grant_valid_nxt   = grant_valid;
      grant_index_nxt   = grant_index;
      timeout_nxt       = 1'b0;
      timeout_index_nxt = '0;
`ifdef TAXI_AXIL_RR_ARB_TIMEOUT_EN
      cnt_nxt           = cnt;
`endif
      case (state)
         IDLE: begin
            if (sel_found) begin
               state_nxt       = BUSY;
               grant_nxt       = PORTS'(1) << sel_idx;
               grant_valid_nxt = 1'b1;
               grant_index_nxt = sel_idx;
`ifdef TAXI_AXIL_RR_ARB_TIMEOUT_EN
               cnt_nxt         = '0;
`endif
            end
         end
         BUSY: begin
            if (release_c) begin
               ptr_nxt = base;
               if (fire) begin
                  timeout_nxt       = 1'b1;
                  timeout_index_nxt = grant_index;
               end
               if (sel_found) begin
                  grant_nxt       = PORTS'(1) << sel_idx;
                  grant_index_nxt = sel_idx;
`ifdef TAXI_AXIL_RR_ARB_TIMEOUT_EN
                  cnt_nxt         = '0;
`endif
               end else begin
                  state_nxt       = IDLE;
                  grant_nxt       = '0;
                  grant_valid_nxt = 1'b0;
               end
            end else begin
`ifdef TAXI_AXIL_RR_ARB_TIMEOUT_EN
               cnt_nxt = cnt + CNT_W'(1);
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         ptr           <= '0;
         grant         <= '0;
         grant_valid   <= 1'b0;
         grant_index   <= '0;
         timeout       <= 1'b0;
         timeout_index <= '0;
`ifdef TAXI_AXIL_RR_ARB_TIMEOUT_EN
         cnt           <= '0;
`endif
      end else begin
         state         <= state_nxt;
         ptr           <= ptr_nxt;
         grant         <= grant_nxt;
         grant_valid   <= grant_valid_nxt;
         grant_index   <= grant_index_nxt;
         timeout       <= timeout_nxt;
         timeout_index <= timeout_index_nxt;
`ifdef TAXI_AXIL_RR_ARB_TIMEOUT_EN
         cnt           <= cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_taxi_axil_rr_arb.sv
// Directed vector bench for taxi_axil_rr_arb with PORTS=4, TIMEOUT=8.
module tb_taxi_axil_rr_arb;

   localparam int unsigned PORTS = 4;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned NVEC  = 27;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] ack;
      logic [3:0] grant;
      logic       gv;
      logic [1:0] gi;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [PORTS-1:0] req;
   logic [PORTS-1:0] ack;
   logic [PORTS-1:0] grant;
   logic             grant_valid;
   logic [IDX_W-1:0] grant_index;
   logic             timeout;
   logic [IDX_W-1:0] timeout_index;

   int n_applied = 0;
   int n_miss    = 0;

   vec_t vecs [NVEC];

   taxi_axil_rr_arb #(
      .PORTS  (PORTS),
      .TIMEOUT(8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .ack          (ack),
      .grant        (grant),
      .grant_valid  (grant_valid),
      .grant_index  (grant_index),
      .timeout      (timeout),
      .timeout_index(timeout_index)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_applied++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [3:0] q, input logic [3:0] a);
      rst = r;
      req = q;
      ack = a;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //               rst   req      ack      grant    gv    gi
      vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
      vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0};
      vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0};
      vecs[3]  = '{1'b0, 4'b1111, 4'b0001, 4'b0010, 1'b1, 2'd1};
      vecs[4]  = '{1'b0, 4'b1111, 4'b0010, 4'b0100, 1'b1, 2'd2};
      vecs[5]  = '{1'b0, 4'b1111, 4'b0100, 4'b1000, 1'b1, 2'd3};
      vecs[6]  = '{1'b0, 4'b1111, 4'b1000, 4'b0001, 1'b1, 2'd0};
      vecs[7]  = '{1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0};
      vecs[8]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2};
      vecs[9]  = '{1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd2};
      vecs[10] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2};
      vecs[11] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0};
      vecs[12] = '{1'b0, 4'b0010, 4'b0001, 4'b0010, 1'b1, 2'd1};
      vecs[13] = '{1'b0, 4'b0010, 4'b1101, 4'b0010, 1'b1, 2'd1};
      vecs[14] = '{1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b1, 2'd1};
      vecs[15] = '{1'b0, 4'b0000, 4'b1101, 4'b0010, 1'b1, 2'd1};
      vecs[16] = '{1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd1};
      vecs[17] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2};
      vecs[18] = '{1'b0, 4'b1011, 4'b0100, 4'b1000, 1'b1, 2'd3};
      vecs[19] = '{1'b0, 4'b1111, 4'b1000, 4'b0001, 1'b1, 2'd0};
      vecs[20] = '{1'b0, 4'b1111, 4'b0001, 4'b0010, 1'b1, 2'd1};
      vecs[21] = '{1'b0, 4'b1111, 4'b0010, 4'b0100, 1'b1, 2'd2};
      vecs[22] = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0};
      vecs[23] = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0};
      vecs[24] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0};
      vecs[25] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0};
      vecs[26] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};

      rst = 1'b1;
      req = '0;
      ack = '0;
      #2;

      for (int i = 0; i < int'(NVEC); i++) begin
         step(vecs[i].rst, vecs[i].req, vecs[i].ack);
         check($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].grant));
         check($sformatf("v%0d grant_valid", i), 32'(grant_valid), 32'(vecs[i].gv));
         check($sformatf("v%0d grant_index", i), 32'(grant_index), 32'(vecs[i].gi));
         check($sformatf("v%0d timeout", i), 32'(timeout), 32'(0));
      end

`ifdef TAXI_AXIL_RR_ARB_TIMEOUT_EN
      // Owner 0 never acks: watchdog hands the grant to port 1 after 8 busy cycles.
      step(1'b1, 4'b0000, 4'b0000);
      step(1'b0, 4'b0011, 4'b0000);
      check("wd0 first grant", 32'(grant), 32'(4'b0001));
      for (int c = 1; c <= 7; c++) begin
         step(1'b0, 4'b0011, 4'b0000);
         check($sformatf("wd0 hold c%0d", c), 32'(grant), 32'(4'b0001));
         check($sformatf("wd0 no timeout c%0d", c), 32'(timeout), 32'(0));
      end
      step(1'b0, 4'b0011, 4'b0000);
      check("wd0 forced grant", 32'(grant), 32'(4'b0010));
      check("wd0 timeout pulse", 32'(timeout), 32'(1));
      check("wd0 timeout_index", 32'(timeout_index), 32'(0));
      step(1'b0, 4'b0011, 4'b0000);
      check("wd0 pulse ends", 32'(timeout), 32'(0));
      check("wd0 new owner holds", 32'(grant), 32'(4'b0010));

      // Ack in the limit cycle wins over the watchdog.
      step(1'b1, 4'b0000, 4'b0000);
      step(1'b0, 4'b0011, 4'b0000);
      check("wd1 first grant", 32'(grant), 32'(4'b0001));
      for (int c = 1; c <= 7; c++) step(1'b0, 4'b0011, 4'b0000);
      step(1'b0, 4'b0011, 4'b0001);
      check("wd1 ack handoff", 32'(grant), 32'(4'b0010));
      check("wd1 no timeout", 32'(timeout), 32'(0));
      step(1'b0, 4'b0011, 4'b0000);
      check("wd1 still no timeout", 32'(timeout), 32'(0));
`else
      // Without the watchdog a silent owner keeps the grant indefinitely.
      step(1'b1, 4'b0000, 4'b0000);
      step(1'b0, 4'b0011, 4'b0000);
      check("hold first grant", 32'(grant), 32'(4'b0001));
      for (int c = 1; c <= 12; c++) begin
         step(1'b0, 4'b0011, 4'b0000);
         check($sformatf("hold c%0d", c), 32'(grant), 32'(4'b0001));
         check($sformatf("hold timeout c%0d", c), 32'(timeout), 32'(0));
      end
      check("hold timeout_index", 32'(timeout_index), 32'(0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
      $finish;
   end

endmodule
